// File: rtl/regfile_scoreboard.sv
// Register file with r0 hardwired to zero, two write-first registered read ports
// and a per-register busy scoreboard. Optional macro: REGFILE_DEBUG_TAP_EN (dbg_regs snapshot).
module regfile_scoreboard #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic                  clock_reg,
  input  logic                  reset,
  input  logic                  write_enable,
  input  logic [ADDR_W-1:0]     write_address,
  input  logic [DATA_W-1:0]     write_data,
  input  logic                  mark_enable,
  input  logic [ADDR_W-1:0]     mark_address,
  input  logic [ADDR_W-1:0]     read_address1,
  input  logic [ADDR_W-1:0]     read_address2,
  output logic [DATA_W-1:0]     read_data1,
  output logic [DATA_W-1:0]     read_data2,
  output logic                  read_busy1,
  output logic                  read_busy2,
  output logic [2**ADDR_W-1:0]  busy_vec
`ifdef REGFILE_DEBUG_TAP_EN
  ,
  output logic [DATA_W*(2**ADDR_W)-1:0] dbg_regs
`endif
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  busy_d;
  logic [DATA_W-1:0] read_data1_q, read_data1_d;
  logic [DATA_W-1:0] read_data2_q, read_data2_d;
  logic              read_busy1_q, read_busy1_d;
  logic              read_busy2_q, read_busy2_d;

  // Next-state register contents and scoreboard; reads see the post-write state.
  always_comb begin
    regs_d[0] = {DATA_W{1'b0}};
    busy_d[0] = 1'b0;
    for (int i = 1; i < DEPTH; i++) begin
      if (write_enable && (write_address == ADDR_W'(i))) begin
        regs_d[i] = write_data;
      end else begin
        regs_d[i] = regs_q[i];
      end
      // A mark in the same cycle as the clearing write means a new producer issued.
      if (mark_enable && (mark_address == ADDR_W'(i))) begin
        busy_d[i] = 1'b1;
      end else if (write_enable && (write_address == ADDR_W'(i))) begin
        busy_d[i] = 1'b0;
      end else begin
        busy_d[i] = busy_q[i];
      end
    end
    read_data1_d = regs_d[read_address1];
    read_data2_d = regs_d[read_address2];
    read_busy1_d = busy_d[read_address1];
    read_busy2_d = busy_d[read_address2];
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock_reg) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= {DATA_W{1'b0}};
      end
      busy_q       <= {DEPTH{1'b0}};
      read_data1_q <= {DATA_W{1'b0}};
      read_data2_q <= {DATA_W{1'b0}};
      read_busy1_q <= 1'b0;
      read_busy2_q <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= regs_d[i];
      end
      busy_q       <= busy_d;
      read_data1_q <= read_data1_d;
      read_data2_q <= read_data2_d;
      read_busy1_q <= read_busy1_d;
      read_busy2_q <= read_busy2_d;
    end
  end

  assign read_data1 = read_data1_q;
  assign read_data2 = read_data2_q;
  assign read_busy1 = read_busy1_q;
  assign read_busy2 = read_busy2_q;
  assign busy_vec   = busy_q;

`ifdef REGFILE_DEBUG_TAP_EN
  logic [DATA_W*DEPTH-1:0] dbg_regs_q;
  logic [DATA_W*DEPTH-1:0] dbg_regs_d;

  // Flatten the post-write register contents into the snapshot bus.
  always_comb begin
    dbg_regs_d = {(DATA_W*DEPTH){1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      dbg_regs_d[i*DATA_W +: DATA_W] = regs_d[i];
    end
  end

  // Snapshot register.
  always_ff @(posedge clock_reg) begin
    if (reset) begin
      dbg_regs_q <= {(DATA_W*DEPTH){1'b0}};
    end else begin
      dbg_regs_q <= dbg_regs_d;
    end
  end

  assign dbg_regs = dbg_regs_q;
`endif

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard with an array-based reference model and
// literal checks on the documented scenarios.
module tb_regfile_scoreboard;

  localparam int DW = 8;
  localparam int AW = 3;
  localparam int N  = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          we;
  logic [AW-1:0] wa;
  logic [DW-1:0] wd;
  logic          me;
  logic [AW-1:0] ma;
  logic [AW-1:0] ra1;
  logic [AW-1:0] ra2;
  logic [DW-1:0] rd1;
  logic [DW-1:0] rd2;
  logic          rb1;
  logic          rb2;
  logic [N-1:0]  bv;
`ifdef REGFILE_DEBUG_TAP_EN
  logic [DW*N-1:0] dbg;
`endif

  regfile_scoreboard #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clock_reg     (clk),
    .reset         (reset),
    .write_enable  (we),
    .write_address (wa),
    .write_data    (wd),
    .mark_enable   (me),
    .mark_address  (ma),
    .read_address1 (ra1),
    .read_address2 (ra2),
    .read_data1    (rd1),
    .read_data2    (rd2),
    .read_busy1    (rb1),
    .read_busy2    (rb2),
    .busy_vec      (bv)
`ifdef REGFILE_DEBUG_TAP_EN
    ,
    .dbg_regs      (dbg)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: register array, busy flags, expected registered outputs.
  logic [DW-1:0]   m_regs [N];
  logic            m_busy [N];
  logic [DW-1:0]   e_rd1, e_rd2;
  logic            e_rb1, e_rb2;
  logic [N-1:0]    e_bv;
  logic [DW*N-1:0] e_dbg;
  bit              m_valid = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        m_regs[i] = '0;
        m_busy[i] = 1'b0;
      end
    end else begin
      if (we && wa != 0) begin
        m_regs[wa] = wd;
        m_busy[wa] = 1'b0;
      end
      if (me && ma != 0) m_busy[ma] = 1'b1;
    end
    e_rd1 = reset ? '0 : m_regs[ra1];
    e_rd2 = reset ? '0 : m_regs[ra2];
    e_rb1 = reset ? 1'b0 : m_busy[ra1];
    e_rb2 = reset ? 1'b0 : m_busy[ra2];
    for (int i = 0; i < N; i++) begin
      e_bv[i] = m_busy[i];
      e_dbg[i*DW +: DW] = m_regs[i];
    end
    m_valid = 1'b1;
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("model_rd1", 64'(rd1), 64'(e_rd1));
      chk("model_rd2", 64'(rd2), 64'(e_rd2));
      chk("model_rb1", 64'(rb1), 64'(e_rb1));
      chk("model_rb2", 64'(rb2), 64'(e_rb2));
      chk("model_busy_vec", 64'(bv), 64'(e_bv));
`ifdef REGFILE_DEBUG_TAP_EN
      chk("model_dbg", 64'(dbg), 64'(e_dbg));
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic m, input logic [AW-1:0] mad,
                       input logic [AW-1:0] r1, input logic [AW-1:0] r2);
    we = w; wa = a; wd = d; me = m; ma = mad; ra1 = r1; ra2 = r2;
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd0, 3'd0);
    tick();
    tick();
    reset = 1'b0;

    // Reads of every address after reset.
    for (int a = 0; a < N; a++) begin
      drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'(a), 3'(7 - a));
      tick();
      chk("reset_rd1", 64'(rd1), 64'h0);
      chk("reset_rd2", 64'(rd2), 64'h0);
      chk("reset_bv", 64'(bv), 64'h0);
    end

    // Write then read; write to r0 dropped.
    drive(1'b1, 3'd3, 8'hA5, 1'b0, 3'd0, 3'd0, 3'd0);
    tick();
    drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd3, 3'd0);
    tick();
    chk("wr3_rd1", 64'(rd1), 64'hA5);
    drive(1'b1, 3'd0, 8'hFF, 1'b0, 3'd0, 3'd0, 3'd0);
    tick();
    drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd0, 3'd0);
    tick();
    chk("wr0_rd1", 64'(rd1), 64'h00);

    // Same-cycle write and read: bypass.
    drive(1'b1, 3'd5, 8'h3C, 1'b0, 3'd0, 3'd3, 3'd5);
    tick();
    chk("bypass_rd2", 64'(rd2), 64'h3C);
    chk("bypass_rd1_other", 64'(rd1), 64'hA5);

    // Scoreboard mark / clear / mark+write.
    drive(1'b0, 3'd0, 8'h00, 1'b1, 3'd2, 3'd2, 3'd0);
    tick();
    chk("mark2_bv", 64'(bv), 64'h04);
    chk("mark2_rb1", 64'(rb1), 64'h1);
    drive(1'b1, 3'd2, 8'h11, 1'b0, 3'd0, 3'd2, 3'd2);
    tick();
    chk("clear2_bv", 64'(bv), 64'h00);
    chk("clear2_rb1", 64'(rb1), 64'h0);
    chk("clear2_rd2", 64'(rd2), 64'h11);
    drive(1'b1, 3'd2, 8'h22, 1'b1, 3'd2, 3'd2, 3'd0);
    tick();
    chk("markwr2_bv", 64'(bv), 64'h04);
    chk("markwr2_rb1", 64'(rb1), 64'h1);
    chk("markwr2_rd1", 64'(rd1), 64'h22);

    // Mark r0 ignored; reset discards a pending mark and write on r6.
    drive(1'b1, 3'd2, 8'h22, 1'b1, 3'd0, 3'd0, 3'd0);
    tick();
    chk("mark0_bv", 64'(bv), 64'h00);
    drive(1'b1, 3'd6, 8'h77, 1'b1, 3'd6, 3'd6, 3'd6);
    reset = 1'b1;
    tick();
    chk("rst_mid_bv", 64'(bv), 64'h00);
    chk("rst_mid_rd1", 64'(rd1), 64'h00);
    reset = 1'b0;
    drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd6, 3'd3);
    tick();
    chk("post_rst_rd1", 64'(rd1), 64'h00);
    chk("post_rst_rd2", 64'(rd2), 64'h00);
    chk("post_rst_bv", 64'(bv), 64'h00);

    // Debug snapshot (register contents are all zero after the reset above).
    drive(1'b1, 3'd1, 8'h01, 1'b0, 3'd0, 3'd0, 3'd0);
    tick();
    drive(1'b1, 3'd7, 8'h80, 1'b0, 3'd0, 3'd1, 3'd7);
    tick();
    chk("r1_r7_rd1", 64'(rd1), 64'h01);
    chk("r1_r7_rd2", 64'(rd2), 64'h80);
`ifdef REGFILE_DEBUG_TAP_EN
    chk("dbg_snapshot", 64'(dbg), 64'h8000_0000_0000_0100);
`endif

    // Overlapping writes/marks across several registers, checked by the model.
    for (int i = 1; i < N; i++) begin
      drive(1'b1, 3'(i), 8'(i * 8'h13), 1'b1, 3'(N - i), 3'(i), 3'(N - i));
      tick();
    end
    for (int i = 0; i < N; i++) begin
      drive(1'b0, 3'd0, 8'h00, (i % 2) == 1, 3'(i), 3'(i), 3'((i + 3) % N));
      tick();
    end
    drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd0, 3'd0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
